fifo_scheduler: RTL and testbench

Arbitration and sequencing front end for the shared 16-entry byte FIFO. Up to NREQ producers compete for the FIFO write port under round-robin arbitration, and one consumer issues read requests. The block issues exactly one FIFO operation per cycle at most, and never drives wr and rd together, because the FIFO gives write priority when both are asserted. It keeps a shadow occupancy count so it never overruns or underruns the FIFO, and it bounds consumer starvation with a write-burst limit.

---
 rtl/fifo_scheduler.sv | 152 +++++++++++++++
 tb/tb_fifo_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_scheduler.sv
// fifo_scheduler: round-robin producer arbitration and read sequencing for a shared byte FIFO.
// Defining FIFO_SCHED_CHECK_EN builds a FIFO-flag consistency checker driving err.
module fifo_scheduler #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    rd_req,
    output logic                    rd_ack,
    output logic                    rd_valid,
    output logic                    fifo_wr,
    output logic                    fifo_rd,
    output logic [DW-1:0]           fifo_din,
    input  logic                    fifo_full,
    input  logic                    fifo_empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    err
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(NREQ);
    localparam int SW = $clog2(MAX_BURST + 1);
    localparam int unsigned NREQ_U = NREQ;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [SW-1:0] BURST_L   = SW'(MAX_BURST);
    localparam logic [GW-1:0] GRANT_RST = GW'(NREQ - 1);

    typedef enum logic {S_WR, S_RD} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [LW-1:0] level_q, level_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [DW-1:0] fifo_din_q, fifo_din_d;
    logic          fifo_wr_q, fifo_rd_q, rd_valid_q;

    logic          found, wr_cand, rd_cand, do_wr, do_rd;
    logic [GW-1:0] pick, idx;
    logic [DW-1:0] sel_data;

    // Search starts one past the last grant so every producer gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = grant_q;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            idx = GW'((32'(grant_q) + k) % NREQ_U);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        sel_data = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            if (pick == GW'(k)) sel_data = req_data[k*DW +: DW];
        end
    end

    always_comb begin
        wr_cand = !rst && found && (level_q < DEPTH_L);
        rd_cand = !rst && rd_req && (level_q != '0);
        // A saturated streak yields to a pending read even before the state flips.
        do_wr = wr_cand && (!rd_cand || (state_q == S_WR && streak_q != BURST_L));
        do_rd = rd_cand && !do_wr;

        req_ready = '0;
        if (do_wr) req_ready[pick] = 1'b1;
        rd_ack = do_rd;

        streak_d = streak_q;
        if (!rd_req || do_rd)
            streak_d = '0;
        else if (do_wr && streak_q != BURST_L)
            streak_d = streak_q + SW'(1);

        state_d = state_q;
        case (state_q)
            S_WR:    if (rd_cand && streak_d == BURST_L) state_d = S_RD;
            S_RD:    if (do_rd || !rd_req) state_d = S_WR;
            default: state_d = S_WR;
        endcase

        level_d = level_q;
        if (do_wr)
            level_d = level_q + LW'(1);
        else if (do_rd)
            level_d = level_q - LW'(1);

        grant_d    = do_wr ? pick : grant_q;
        fifo_din_d = do_wr ? sel_data : fifo_din_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_WR;
            streak_q   <= '0;
            level_q    <= '0;
            grant_q    <= GRANT_RST;
            fifo_din_q <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            level_q    <= level_d;
            grant_q    <= grant_d;
            fifo_din_q <= fifo_din_d;
            fifo_wr_q  <= do_wr;
            fifo_rd_q  <= do_rd;
            rd_valid_q <= fifo_rd_q;
        end
    end

    assign fifo_wr  = fifo_wr_q;
    assign fifo_rd  = fifo_rd_q;
    assign fifo_din = fifo_din_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;
    assign grant_id = grant_q;

`ifdef FIFO_SCHED_CHECK_EN
    // The FIFO count trails the shadow level by one edge, so compare against a delayed copy.
    logic [LW-1:0] level_dly_q;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_dly_q <= '0;
            err_q       <= 1'b0;
        end else begin
            level_dly_q <= level_q;
            if ((fifo_full != (level_dly_q == DEPTH_L)) ||
                (fifo_empty != (level_dly_q == '0)) ||
                (fifo_wr_q && fifo_rd_q))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_flags;
    assign unused_flags = fifo_full ^ fifo_empty;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_scheduler.sv
// Self-checking bench for fifo_scheduler with a behavioural 16-entry FIFO and data scoreboard.
module tb_fifo_scheduler;
    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int MAX_BURST = 4;
`ifdef FIFO_SCHED_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rd_req = 1'b0;
    logic              rd_ack, rd_valid, fifo_wr, fifo_rd;
    logic [DW-1:0]     fifo_din;
    logic              ffull, fempty;
    logic [4:0]        level;
    logic [1:0]        grant_id;
    logic              err;
    logic              force_empty = 1'b0;

    always #5 clk = ~clk;

    fifo_scheduler #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
        .fifo_full(ffull), .fifo_empty(fempty), .level(level),
        .grant_id(grant_id), .err(err)
    );

    // Behavioural FIFO: write priority, registered dout.
    logic [7:0] fmem [16];
    logic [3:0] fwp, frp;
    logic [4:0] fcnt;
    logic [7:0] fdout;
    always @(posedge clk) begin
        if (rst) begin
            fwp <= '0; frp <= '0; fcnt <= '0; fdout <= '0;
        end else if (fifo_wr && fcnt != 5'd16) begin
            fmem[fwp] <= fifo_din; fwp <= fwp + 4'd1; fcnt <= fcnt + 5'd1;
        end else if (fifo_rd && fcnt != 5'd0) begin
            fdout <= fmem[frp]; frp <= frp + 4'd1; fcnt <= fcnt - 5'd1;
        end
    end
    assign ffull  = (fcnt == 5'd16);
    assign fempty = (fcnt == 5'd0) | force_empty;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] wr_exp [$];
    logic [7:0] rd_exp [$];
    logic [7:0] exp_fifo [$];

    task automatic exp_write(input logic [7:0] d);
        wr_exp.push_back(d);
        exp_fifo.push_back(d);
    endtask

    task automatic exp_read();
        if (exp_fifo.size() != 0) rd_exp.push_back(exp_fifo.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe timing and data scoreboard, sampled on the falling edge.
    logic [1:0] wpipe = '0;
    logic [1:0] rpipe = '0;
    always @(negedge clk) begin
        check("mutex", {31'b0, fifo_wr & fifo_rd}, 0);
        check("wr_strobe", {31'b0, fifo_wr}, {31'b0, wpipe[0]});
        check("rd_strobe", {31'b0, fifo_rd}, {31'b0, rpipe[0]});
        check("rd_valid_lat", {31'b0, rd_valid}, {31'b0, rpipe[1]});
        if (fifo_wr) begin
            if (wr_exp.size() == 0) check("wr_extra", {31'b0, fifo_wr}, 0);
            else check("wr_data", {24'b0, fifo_din}, {24'b0, wr_exp.pop_front()});
        end
        if (rd_valid) begin
            if (rd_exp.size() == 0) check("rd_extra", {31'b0, rd_valid}, 0);
            else check("rd_data", {24'b0, fdout}, {24'b0, rd_exp.pop_front()});
        end
        wpipe = {wpipe[0], |(req_valid & req_ready)};
        rpipe = {rpipe[0], rd_req & rd_ack};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int         g;
    int         last_g;
    logic [7:0] pd;
    logic       is_rd;

    initial begin
        // Reset with requests already asserted: nothing may be accepted.
        req_valid = 4'hF;
        rd_req    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_ack", rd_ack, 0);
        check("rst_level", level, 0);
        check("rst_grant", grant_id, 3);
        check("rst_din", fifo_din, 0);
        check("rst_err", err, 0);
        check("rst_rdvalid", rd_valid, 0);

        // Fill: all producers valid, round-robin from producer 0.
        step();
        rst = 1'b0; rd_req = 1'b0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        last_g = NREQ - 1;
        for (int k = 0; k < 16; k++) begin
            g = (last_g + 1) % NREQ;
            @(negedge clk);
            check("fill_ready", req_ready, 1 << g);
            check("fill_level", level, k);
            exp_write(8'(8'h10 + g));
            last_g = g;
            step();
        end
        @(negedge clk);
        check("full_ready", req_ready, 0);
        check("full_level", level, 16);
        check("full_grant", grant_id, 3);
        step();
        @(negedge clk);
        check("full_ready_hold", req_ready, 0);

        // Drain the full FIFO with rd_req held.
        step();
        req_valid = '0; rd_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("drain_ack", rd_ack, 1);
            check("drain_level", level, 16 - k);
            exp_read();
            step();
        end
        @(negedge clk);
        check("empty_ack", rd_ack, 0);
        check("empty_level", level, 0);
        step();
        rd_req = 1'b0;

        // Producer 2 alone up to level 5, then contend with reads.
        req_valid = 4'b0100; pd = 8'h40; req_data[23:16] = pd;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("pre_ready", req_ready, 4'b0100);
            exp_write(pd); pd++;
            step();
            req_data[23:16] = pd;
        end
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            is_rd = (i % 5 == 4);
            @(negedge clk);
            check("burst_wr", req_ready, is_rd ? 4'b0000 : 4'b0100);
            check("burst_rd", rd_ack, is_rd);
            if (is_rd) exp_read();
            else begin exp_write(pd); pd++; end
            step();
            req_data[23:16] = pd;
        end
        req_valid = '0; rd_req = 1'b0;
        last_g = 2;
        @(negedge clk);
        check("burst_level", level, 11);
        step();
        rd_req = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check("drain2_ack", rd_ack, 1);
            exp_read();
            step();
        end
        rd_req = 1'b0;
        @(negedge clk);
        check("drain2_level", level, 0);
        repeat (3) step();

        // Single write then immediate read of the same entry.
        req_valid = 4'b0010; req_data[15:8] = 8'hA5;
        @(negedge clk);
        check("wa5_ready", req_ready, 4'b0010);
        check("wa5_noack", rd_ack, 0);
        exp_write(8'hA5); last_g = 1;
        step();
        req_valid = '0; rd_req = 1'b1;
        @(negedge clk);
        check("ra5_ack", rd_ack, 1);
        exp_read();
        step();
        rd_req = 1'b0;
        @(negedge clk);
        check("ra5_early", rd_valid, 0);
        @(negedge clk);
        check("ra5_valid", rd_valid, 1);
        check("ra5_dout", fdout, 8'hA5);
        repeat (2) step();

        // Reset in the middle of a write stream at level 7.
        req_valid = 4'hF; req_data = {8'h53, 8'h52, 8'h51, 8'h50};
        for (int k = 0; k < 7; k++) begin
            g = (last_g + 1) % NREQ;
            @(negedge clk);
            check("stream_ready", req_ready, 1 << g);
            exp_write(8'(8'h50 + g));
            last_g = g;
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_level7", level, 7);
        check("mid_rst_ready", req_ready, 0);
        exp_fifo.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_wr", fifo_wr, 0);
        check("post_rst_level", level, 0);
        check("post_rst_grant", grant_id, 3);
        check("post_rst_first", req_ready, 4'b0001);
        exp_write(8'h50);
        step();
        req_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("p0_ready", req_ready, 4'b0001);
            exp_write(8'h50);
            step();
        end
        req_valid = '0;

        // Flag checker: a forced empty flag at level 3.
        repeat (3) step();
        @(negedge clk);
        check("err_clean", err, 0);
        check("chk_level", level, 3);
        step();
        force_empty = 1'b1;
        step();
        force_empty = 1'b0;
        @(negedge clk);
        check("err_set", err, CHK);
        repeat (4) step();
        @(negedge clk);
        check("err_sticky", err, CHK);
        step();
        rst = 1'b1;
        exp_fifo.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("err_clear", err, 0);
        check("final_level", level, 0);
        repeat (3) step();
        check("wr_left", wr_exp.size(), 0);
        check("rd_left", rd_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
